// File: rtl/hash_pkg.sv
// Shared types and widths for the hash message feeder slice.
package hash_pkg;

    localparam int unsigned LEN_W  = 64;
    localparam int unsigned DIG_W  = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT_HASH,
        DONE
    } state_t;

endpackage

// File: rtl/hash_byte_fifo.sv
// Small byte FIFO: synchronous write, registered read, wrap-bit pointers.
module hash_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Storage array, no reset needed on data.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                dout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hash_msg_feeder.sv
// Feeds a length-prefixed byte stream into the hash core and returns its digest.
module hash_msg_feeder
    import hash_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    output logic              busy,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] message,
    output logic              M_valid,
    output logic [LEN_W-1:0]  counter,
    input  logic              hash_ready,
    input  logic [DIG_W-1:0]  digest_in,
    output logic [DIG_W-1:0]  dig_out,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic              err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

    state_t             state;
    logic [LEN_W-1:0]   acc_cnt;
    logic [LEN_W-1:0]   fed_cnt;
    logic [TMR_W-1:0]   timer;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Accept only while room remains both in the FIFO and in the message.
    assign in_ready = (state == FEED) && !fifo_full && (acc_cnt < counter);
    assign push     = in_valid && in_ready;
    // Drain one byte per cycle whenever something is buffered.
    assign pop      = (state == FEED) && !fifo_empty && (fed_cnt < counter);

    hash_byte_fifo #(
        .DEPTH (DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (message),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Control FSM with counters, timeout and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            fed_cnt   <= '0;
            timer     <= '0;
            counter   <= '0;
            busy      <= 1'b0;
            M_valid   <= 1'b0;
            dig_out   <= '0;
            dig_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err     <= 1'b0;
            M_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (msg_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            counter <= msg_len;
                            acc_cnt <= '0;
                            fed_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (push) begin
                        acc_cnt <= acc_cnt + LEN_W'(1);
                    end
                    if (pop) begin
                        M_valid <= 1'b1;
                        fed_cnt <= fed_cnt + LEN_W'(1);
                    end
                    if (fed_cnt == counter) begin
                        timer <= '0;
                        state <= WAIT_HASH;
                    end
                end
                WAIT_HASH: begin
                    timer <= timer + TMR_W'(1);
                    // Completion takes priority over an expiring timer.
                    if (hash_ready) begin
                        dig_out   <= digest_in;
                        dig_valid <= 1'b1;
                        state     <= DONE;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        counter <= '0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        busy      <= 1'b0;
                        counter   <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Randomised bench for hash_msg_feeder against a queue-based reference model.
module tb_hash_msg_feeder;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] msg_len;
    logic        busy;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  message;
    logic        M_valid;
    logic [63:0] counter;
    logic        hash_ready;
    logic [31:0] digest_in;
    logic [31:0] dig_out;
    logic        dig_valid;
    logic        dig_ready;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    hash_msg_feeder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg_len    (msg_len),
        .busy       (busy),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .message    (message),
        .M_valid    (M_valid),
        .counter    (counter),
        .hash_ready (hash_ready),
        .digest_in  (digest_in),
        .dig_out    (dig_out),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     64'(busy),      64'(0));
        check({tag, "_in_ready"}, 64'(in_ready),  64'(0));
        check({tag, "_message"},  64'(message),   64'(0));
        check({tag, "_M_valid"},  64'(M_valid),   64'(0));
        check({tag, "_counter"},  counter,        64'(0));
        check({tag, "_dig_out"},  64'(dig_out),   64'(0));
        check({tag, "_dig_valid"},64'(dig_valid), 64'(0));
        check({tag, "_err"},      64'(err),       64'(0));
    endtask

    // One full message: vmode 0=continuous, 1=pattern 1,0,0, 2=random valid.
    // h = WAIT_HASH cycle on which hash_ready is raised (0 = never).
    task automatic run_msg(input int len, input int vmode, input int base,
                           input int h, input logic [31:0] dg, input int stall,
                           input bit poke_start);
        logic [7:0] src[$];
        logic [7:0] mq[$];
        logic [7:0] pbyte;
        int  acc;
        int  mv;
        int  budget;
        bit  pend;
        bit  exp_rdy;
        bit  got_hash;

        for (int i = 0; i < len; i++) begin
            src.push_back((base >= 0) ? 8'(base + i) : 8'($urandom));
        end

        check("idle_busy", 64'(busy), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(0));
        start   = 1'b1;
        msg_len = 64'(len);
        cyc();
        start   = 1'b0;
        check("start_busy", 64'(busy), 64'(1));

        acc = 0; mv = 0; budget = 0; pend = 1'b0; pbyte = '0;
        while (mv < len) begin
            if (budget > 400) begin
                check("feed_bound", 64'(mv), 64'(len));
                break;
            end
            check("feed_M_valid", 64'(M_valid), 64'(pend));
            if (pend) begin
                check("feed_message", 64'(message), 64'(pbyte));
                mv++;
            end
            check("feed_counter", counter, 64'(len));
            check("feed_busy", 64'(busy), 64'(1));
            exp_rdy = (acc < len) && (mq.size() < DEPTH);
            check("feed_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (mv == len) break;

            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (budget % 3 == 0);
                default: in_valid = 1'($urandom % 2);
            endcase
            in_data = (acc < len) ? src[acc] : 8'($urandom);
            if (poke_start && budget == 2) begin
                start   = 1'b1;
                msg_len = 64'($urandom_range(1, 50));
            end

            pend = (mq.size() > 0);
            if (pend) pbyte = mq.pop_front();
            if (in_valid && exp_rdy) begin
                mq.push_back(in_data);
                acc++;
            end
            cyc();
            start = 1'b0;
            budget++;
        end
        in_valid = 1'b0;
        cyc();

        got_hash = 1'b0;
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            check("wait_busy", 64'(busy), 64'(1));
            check("wait_M_valid", 64'(M_valid), 64'(0));
            check("wait_in_ready", 64'(in_ready), 64'(0));
            check("wait_dig_valid", 64'(dig_valid), 64'(0));
            check("wait_err", 64'(err), 64'(0));
            if (k == h) begin
                hash_ready = 1'b1;
                digest_in  = dg;
                cyc();
                hash_ready = 1'b0;
                digest_in  = $urandom;
                got_hash   = 1'b1;
                break;
            end
            cyc();
        end

        if (!got_hash) begin
            check("tmo_err", 64'(err), 64'(1));
            check("tmo_busy", 64'(busy), 64'(0));
            check("tmo_dig_valid", 64'(dig_valid), 64'(0));
            cyc();
            check("tmo_err_pulse", 64'(err), 64'(0));
            return;
        end

        check("done_dig_valid", 64'(dig_valid), 64'(1));
        check("done_dig_out", 64'(dig_out), 64'(dg));
        check("done_err", 64'(err), 64'(0));
        check("done_busy", 64'(busy), 64'(1));
        for (int s = 0; s < stall; s++) begin
            dig_ready = 1'b0;
            digest_in = $urandom;
            cyc();
            check("stall_dig_valid", 64'(dig_valid), 64'(1));
            check("stall_dig_out", 64'(dig_out), 64'(dg));
            check("stall_busy", 64'(busy), 64'(1));
        end
        dig_ready = 1'b1;
        cyc();
        dig_ready = 1'b0;
        check("ack_dig_valid", 64'(dig_valid), 64'(0));
        check("ack_busy", 64'(busy), 64'(0));
        check("ack_counter", counter, 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; msg_len = '0; in_data = '0; in_valid = 1'b0;
        hash_ready = 1'b0; digest_in = '0; dig_ready = 1'b0;
        #2;
        check_all_zero("reset");
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Directed scenarios.
        run_msg(3, 0, 8'h61, 1, 32'hDEADBEEF, 0, 1'b0);
        run_msg(10, 0, 8'h10, 3, 32'h12345678, 0, 1'b0);
        run_msg(4, 1, 8'hA0, 2, 32'hCAFEF00D, 0, 1'b0);
        run_msg(6, 0, 8'h30, 0, 32'h0, 0, 1'b0);
        run_msg(5, 2, -1, 16, 32'h0BADC0DE, 0, 1'b0);
        run_msg(7, 0, -1, 4, 32'h55AA55AA, 5, 1'b1);

        // Zero-length command.
        start = 1'b1; msg_len = '0;
        cyc();
        start = 1'b0;
        check("zero_err", 64'(err), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        check("zero_M_valid", 64'(M_valid), 64'(0));
        cyc();
        check("zero_err_pulse", 64'(err), 64'(0));
        check("zero_busy2", 64'(busy), 64'(0));

        // Reset asserted mid-message.
        start = 1'b1; msg_len = 64'd8;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_in_ready", 64'(in_ready), 64'(0));
        run_msg(5, 0, 8'hC0, 2, 32'h600DF00D, 1, 1'b0);

        // Randomised messages.
        for (int n = 0; n < 30; n++) begin
            run_msg($urandom_range(1, 20), $urandom_range(0, 2), -1,
                    $urandom_range(0, 20), $urandom, $urandom_range(0, 4),
                    1'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
